// File: rtl/dtfm_deser.sv
// dtfm_deser: recovers framed telemetry words from an asynchronous dCLK/dFM/dDAT serial stream
// Ports: clk/reset   system clock, synchronous active-high reset
//        dCLK/dFM/dDAT  asynchronous serial bit clock, frame marker and data
//        wData/wValid/wIdx/FRM  assembled word, strobe, position in frame, frame-start strobe
//        locked/errMark/errLost/frmCnt  alignment status, marker error, dCLK loss, frame count
module dtfm_deser #(
   parameter int WORD_W      = 16,
   parameter int FRAME_WORDS = 640,
   parameter int MSB_FIRST   = 1,
   parameter int TIMEOUT     = 256
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           dCLK,
   input  logic                           dFM,
   input  logic                           dDAT,
   output logic [WORD_W-1:0]              wData,
   output logic                           wValid,
   output logic [$clog2(FRAME_WORDS)-1:0] wIdx,
   output logic                           FRM,
   output logic                           locked,
   output logic                           errMark,
   output logic                           errLost,
   output logic [15:0]                    frmCnt
);
   localparam int IW = $clog2(FRAME_WORDS);
   localparam int BW = $clog2(WORD_W);
   typedef enum logic {HUNT, LOCK} state_t;
   state_t state, state_n;
   logic [2:0] clk_sync;
   logic [1:0] fm_sync, dat_sync;
   logic [WORD_W-1:0] sreg, sbase, sh;
   logic [BW-1:0] bcnt, bbase;
   logic [IW-1:0] wpos, wbase;
   logic [15:0] tcnt;
   logic s, fm, dat, p_nz, take, fresh, lost, mark, done;
   // falling edge of the synchronised dCLK lands mid-bit, where dFM/dDAT are stable
   assign s      = clk_sync[2] & ~clk_sync[1];
   assign fm     = fm_sync[1];
   assign dat    = dat_sync[1];
   assign p_nz   = (bcnt != '0) || (wpos != '0);
   assign locked = (state == LOCK);
   always_comb begin
      state_n = state;
      take    = 1'b0;
      fresh   = 1'b0;
      lost    = 1'b0;
      mark    = 1'b0;
      if (state == HUNT) begin
         if (s && fm) begin
            state_n = LOCK;
            take    = 1'b1;
            fresh   = 1'b1;
         end
      end else if (tcnt == 16'(TIMEOUT - 1)) begin
         // timeout wins over a coincident strobe
         lost    = 1'b1;
         state_n = HUNT;
      end else if (s) begin
         if (fm && p_nz) begin
            mark  = 1'b1;
            take  = 1'b1;
            fresh = 1'b1;
         end else if (!fm && !p_nz) begin
            mark    = 1'b1;
            state_n = HUNT;
         end else begin
            take = 1'b1;
         end
      end
      // a fresh start makes the current bit bit 0 of word 0, dropping any partial word
      sbase = fresh ? '0 : sreg;
      bbase = fresh ? '0 : bcnt;
      wbase = fresh ? '0 : wpos;
      sh    = (MSB_FIRST != 0) ? {sbase[WORD_W-2:0], dat} : {dat, sbase[WORD_W-1:1]};
      done  = take && (bbase == BW'(WORD_W - 1));
   end
   always_ff @(posedge clk) begin
      if (reset) state <= HUNT;
      else       state <= state_n;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync <= '0;
         fm_sync  <= '0;
         dat_sync <= '0;
         sreg     <= '0;
         bcnt     <= '0;
         wpos     <= '0;
         tcnt     <= '0;
         wData    <= '0;
         wValid   <= 1'b0;
         wIdx     <= '0;
         FRM      <= 1'b0;
         errMark  <= 1'b0;
         errLost  <= 1'b0;
         frmCnt   <= '0;
      end else begin
         clk_sync <= {clk_sync[1:0], dCLK};
         fm_sync  <= {fm_sync[0], dFM};
         dat_sync <= {dat_sync[0], dDAT};
         wValid   <= 1'b0;
         FRM      <= 1'b0;
         errMark  <= mark;
         errLost  <= lost;
         tcnt     <= (state == LOCK && !s && !lost) ? tcnt + 16'd1 : '0;
         if (state_n == HUNT) begin
            bcnt <= '0;
            wpos <= '0;
         end else if (take) begin
            sreg <= sh;
            bcnt <= done ? '0 : bbase + 1'b1;
            wpos <= wbase;
            if (done) begin
               wData  <= sh;
               wValid <= 1'b1;
               wIdx   <= wbase;
               FRM    <= (wbase == '0);
               wpos   <= (wbase == IW'(FRAME_WORDS - 1)) ? '0 : wbase + 1'b1;
               frmCnt <= frmCnt + 16'(wbase == IW'(FRAME_WORDS - 1));
            end
         end
      end
   end
endmodule

// File: tb/tb_dtfm_deser.sv
// tb_dtfm_deser: randomized frame stream against a word-queue reference model
module tb_dtfm_deser;
   localparam int W = 12, N = 8, TO = 256, IW = 3, HALF = 37;
   logic clk = 0, reset = 1, dCLK = 0, dFM = 0, dDAT = 0;
   logic [W-1:0] wData;
   logic wValid, FRM, locked, errMark, errLost;
   logic [IW-1:0] wIdx;
   logic [15:0] frmCnt;
   int checks = 0, errors = 0, cyc = 0;
   int n_mark = 0, n_lost = 0, n_valid = 0, last_valid_cyc = 0, lost_cyc = 0, exp_frames = 0;
   logic [IW+W-1:0] exp_q[$];

   dtfm_deser #(.WORD_W(W), .FRAME_WORDS(N), .MSB_FIRST(0), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .dCLK(dCLK), .dFM(dFM), .dDAT(dDAT),
      .wData(wData), .wValid(wValid), .wIdx(wIdx), .FRM(FRM), .locked(locked),
      .errMark(errMark), .errLost(errLost), .frmCnt(frmCnt));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [IW+W-1:0] e;
      if (wValid) begin
         n_valid++;
         last_valid_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: wData=%h wIdx=%0d, none expected", wData, wIdx);
         end else begin
            e = exp_q.pop_front();
            if (wData !== e[W-1:0] || wIdx !== e[IW+W-1:W] || FRM !== (e[IW+W-1:W] == 0)) begin
               errors++;
               $display("FAIL word: got data=%h idx=%0d frm=%b, want data=%h idx=%0d frm=%b",
                        wData, wIdx, FRM, e[W-1:0], e[IW+W-1:W], e[IW+W-1:W] == 0);
            end
         end
      end else if (FRM) begin
         checks++;
         errors++;
         $display("FAIL frm_without_valid: FRM=1 wValid=0, want FRM=0");
      end
      if (errMark) n_mark++;
      if (errLost) begin
         n_lost++;
         lost_cyc = cyc;
      end
      if (errMark || errLost) begin
         checks++;
         if (errMark && errLost) begin
            errors++;
            $display("FAIL err_exclusive: errMark=1 errLost=1, want not both");
         end
      end
   end

   task automatic send_bit(input logic fm, input logic d);
      dCLK = 1; dFM = fm; dDAT = d;
      #HALF;
      dCLK = 0;
      #HALF;
   endtask

   task automatic send_word(input logic [W-1:0] v, input logic fm, input int idx, input bit expect_it);
      if (expect_it) begin
         exp_q.push_back({IW'(idx), v});
         if (idx == N - 1) exp_frames++;
      end
      for (int i = 0; i < W; i++) send_bit(fm && i == 0, v[i]);
   endtask

   task automatic send_frame(input bit first_abc);
      for (int w = 0; w < N; w++)
         send_word((first_abc && w == 0) ? 12'hABC : W'($urandom_range(0, (1 << W) - 1)), w == 0, w, 1);
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
   endtask

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_int("reset_outputs", int'({wData, wValid, wIdx, FRM, errMark, errLost}), 0);
      check_int("reset_status", int'({locked, frmCnt}), 0);
      reset = 0;
      settle();
   endtask

   task automatic test_frames();
      int m0 = n_mark, l0 = n_lost, v0 = n_valid;
      send_frame(1);
      send_frame(0);
      send_frame(0);
      settle();
      check_int("frames_missing_words", exp_q.size(), 0);
      check_int("frames_valid_count", n_valid - v0, 3 * N);
      check_int("frames_frmcnt", int'(frmCnt), exp_frames);
      check_int("frames_locked", int'(locked), 1);
      check_int("frames_errmark", n_mark - m0, 0);
      check_int("frames_errlost", n_lost - l0, 0);
   endtask

   task automatic test_timeout();
      int m0 = n_mark, l0 = n_lost;
      repeat (300) @(negedge clk);
      check_int("timeout_errlost", n_lost - l0, 1);
      check_int("timeout_delay", lost_cyc - last_valid_cyc, TO);
      check_int("timeout_unlocked", int'(locked), 0);
      check_int("timeout_no_errmark", n_mark - m0, 0);
      send_word(W'($urandom_range(0, 4095)), 0, 0, 0);
      send_word(W'($urandom_range(0, 4095)), 0, 0, 0);
      send_frame(0);
      settle();
      check_int("resync_missing_words", exp_q.size(), 0);
      check_int("resync_frmcnt", int'(frmCnt), exp_frames);
      check_int("resync_locked", int'(locked), 1);
   endtask

   task automatic test_misplaced();
      int m0 = n_mark;
      logic [W-1:0] v0;
      for (int w = 0; w < 3; w++) send_word(W'($urandom_range(0, 4095)), w == 0, w, 1);
      for (int i = 0; i < 5; i++) send_bit(0, 1'($urandom_range(0, 1)));
      v0 = W'($urandom_range(0, 4095));
      exp_q.push_back({IW'(0), v0});
      send_bit(1, v0[0]);
      check_int("misplaced_errmark", n_mark - m0, 1);
      for (int i = 1; i < W; i++) send_bit(0, v0[i]);
      for (int w = 1; w < N; w++) send_word(W'($urandom_range(0, 4095)), 0, w, 1);
      settle();
      check_int("misplaced_missing_words", exp_q.size(), 0);
      check_int("misplaced_locked", int'(locked), 1);
      check_int("misplaced_frmcnt", int'(frmCnt), exp_frames);
   endtask

   task automatic test_missing();
      int m0 = n_mark, v0 = n_valid;
      send_bit(0, 1);
      settle();
      check_int("missing_errmark", n_mark - m0, 1);
      check_int("missing_unlocked", int'(locked), 0);
      for (int i = 1; i < W; i++) send_bit(0, 1'($urandom_range(0, 1)));
      send_word(W'($urandom_range(0, 4095)), 0, 0, 0);
      check_int("missing_no_words", n_valid - v0, 0);
      send_frame(0);
      settle();
      check_int("missing_missing_words", exp_q.size(), 0);
      check_int("missing_relocked", int'(locked), 1);
   endtask

   task automatic test_reset_mid();
      int m0, v0;
      for (int w = 0; w < 4; w++) send_word(W'($urandom_range(0, 4095)), w == 0, w, 1);
      for (int i = 0; i < 5; i++) send_bit(0, 1'($urandom_range(0, 1)));
      dCLK = 1;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      check_int("midreset_outputs", int'({wData, wValid, wIdx, FRM, errMark, errLost}), 0);
      check_int("midreset_status", int'({locked, frmCnt}), 0);
      exp_frames = 0;
      check_int("midreset_words_drained", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 0;
      m0 = n_mark;
      v0 = n_valid;
      repeat (10) @(negedge clk);
      check_int("midreset_no_false_strobe", (n_valid - v0) + (n_mark - m0) + int'(locked), 0);
      dCLK = 0;
      #HALF;
      send_frame(0);
      settle();
      check_int("midreset_missing_words", exp_q.size(), 0);
      check_int("midreset_frmcnt", int'(frmCnt), 1);
      check_int("midreset_locked", int'(locked), 1);
   endtask

   initial begin
      test_reset();
      test_frames();
      test_timeout();
      test_misplaced();
      test_missing();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
